pe_mac_sequencer: RTL and testbench
===================================

# pe_mac_sequencer

Sequencer for one multiply-accumulate processing element (8-bit operand multiplier feeding a 32-bit signed accumulator that adds every clock and clears on its reset). The block accepts a vector length and a start pulse. It clears the PE accumulator, then streams exactly `vec_len` operand pairs into the PE over a valid/ready handshake, driving zero operands whenever no pair is transferred. It waits out the PE accumulate latency, captures the final sum, and presents it on a valid/ready result port. It sits between the operand fetch logic and one PE instance, and owns that PE's clear input.

## Interface
- `DATA_WIDTH`, 8: operand width; must equal the PE input width.
- `ACC_WIDTH`, 32: accumulator/result width; must equal the PE output width.
- `LEN_WIDTH`, 8: width of the vector-length field (max 255 pairs).
- `clk`  in  1  clock; single clock domain, rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle command strobe; honoured only in IDLE.
- `vec_len`  in  LEN_WIDTH  number of operand pairs; sampled when `start` is accepted.
- `busy`  out  1  high in every state except IDLE.
- `in_valid`  in  1  operand pair valid.
- `in_ready`  out  1  high only in RUN.
- `in_a`, `in_b`  in  DATA_WIDTH each  operand pair.
- `pe_a`, `pe_b`  out  DATA_WIDTH each  registered operands to the PE; 0 when no pair is being fed.
- `pe_clear`  out  1  drives the PE reset: `reset` OR (state == CLEAR).
- `pe_result`  in  ACC_WIDTH  PE accumulator value (signed).
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  result consumer ready.
- `out_data`  out  ACC_WIDTH  captured signed sum; stable while `out_valid` is high.

## Operation
- States: IDLE, CLEAR, RUN, DRAIN, CAPTURE, OUT.
- IDLE:
  - `start` = 1: latch `vec_len` into `len_q`, zero `cnt`, go to CLEAR.
  - Otherwise stay in IDLE.
- CLEAR (1 cycle): `pe_clear` = 1, `pe_a`/`pe_b` <= 0.
  - `len_q` = 0: go to CAPTURE (result is 0).
  - Otherwise go to RUN.
- RUN: `in_ready` = 1.
  - Transfer (`in_valid` & `in_ready`): `pe_a` <= `in_a`, `pe_b` <= `in_b`, `cnt` <= `cnt` + 1.
  - No transfer: `pe_a`/`pe_b` <= 0. Operand 8'h00 yields a zero product, so idle cycles add nothing.
  - Transfer with `cnt` == `len_q` − 1: go to DRAIN.
- DRAIN (1 cycle): the last pair is on `pe_a`/`pe_b`, and the PE accumulates it at the end of this cycle. `pe_a`/`pe_b` <= 0. Go to CAPTURE.
- CAPTURE (1 cycle): `out_data` <= `pe_result`, `out_valid` <= 1. Go to OUT.
- OUT: hold `out_data` and `out_valid`.
  - `out_ready` = 1: `out_valid` <= 0, go to IDLE. `start` in that same cycle is ignored.
- `start` outside IDLE is ignored; no queueing.
- `cnt` and `len_q` are LEN_WIDTH wide. `cnt` never wraps, because RUN exits at `len_q` − 1.
- The PE accumulator is never cleared by this block except in CLEAR and during `reset`. Overflow wraps in the PE (two's complement); the block does not detect it.

## Timing
- Reset (synchronous): state = IDLE, `busy` = 0, `in_ready` = 0, `out_valid` = 0, `out_data` = 0, `pe_a` = `pe_b` = 0, `cnt` = 0, `len_q` = 0.
- `pe_clear` = 1 combinationally while `reset` is high. This clears the PE regardless of its own reset style.
- Reset mid-operation: the partial vector is discarded, any pending result is dropped, and the next cycle is IDLE.
- `start` accepted at edge t0:
  - CLEAR during cycle t0..t1.
  - RUN from t1; `in_ready` is first high in that cycle.
- With back-to-back `in_valid`, N pairs transfer on edges t1+1 … t1+N.
- Last transfer at edge e:
  - DRAIN during e..e+1.
  - CAPTURE during e+1..e+2.
  - `out_valid` high from e+2.
- Command-to-result latency with no stalls: N + 3 edges after the start edge for N ≥ 1; 2 edges for N = 0.
- `in_valid` gaps stretch RUN one cycle per gap; no pair is lost or duplicated.
- `out_valid`/`out_data` must not change while `out_valid` = 1 and `out_ready` = 0.
- Next `start` is accepted no earlier than the cycle after the OUT → IDLE transition.

## Test plan
The bench uses a behavioural PE stub that accumulates the unsigned product a·b into a signed 32-bit sum.
- Reset then idle: all outputs 0, `pe_clear` = 1 during reset; no `start` → `busy` stays 0.
- `start`, `vec_len` = 4, pairs (1,2) (3,4) (5,6) (7,8) back-to-back, `out_ready` = 1 → `out_data` = 100, `out_valid` pulses exactly 1 cycle, 7 edges after `start`; `busy` falls next cycle.
- `vec_len` = 3 with `in_valid` low on alternate cycles, pairs (10,10) (2,3) (1,1) → `out_data` = 107; exactly 3 transfers; `pe_a` = 0 on gap cycles.
- `vec_len` = 0 → `pe_clear` pulse, `out_data` = 0, `out_valid` 2 edges after `start`, no `in_ready`.
- Back-to-back commands: vector (2,2)×2 then (1,1)×1, with `out_ready` held low 5 cycles on the first result → first `out_data` = 8 holds stable throughout; `start` during OUT ignored; second `out_data` = 1, proving the accumulator was cleared.
- `reset` asserted after 2 of 4 pairs → IDLE next cycle, no `out_valid`; a new `vec_len` = 1 pair (9,9) → 81.

Source files
------------

// File: rtl/pe_mac_sequencer.sv
// Sequencer for one multiply-accumulate PE: clears the accumulator, streams vec_len
// operand pairs over valid/ready, waits out the PE latency and returns the captured sum.
module pe_mac_sequencer #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ACC_WIDTH  = 32,
  parameter int unsigned LEN_WIDTH  = 8
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_start,
  input  logic [LEN_WIDTH-1:0]  i_vec_len,
  output logic                  o_busy,
  input  logic                  i_in_valid,
  output logic                  o_in_ready,
  input  logic [DATA_WIDTH-1:0] i_in_a,
  input  logic [DATA_WIDTH-1:0] i_in_b,
  output logic [DATA_WIDTH-1:0] o_pe_a,
  output logic [DATA_WIDTH-1:0] o_pe_b,
  output logic                  o_pe_clear,
  input  logic [ACC_WIDTH-1:0]  i_pe_result,
  output logic                  o_out_valid,
  input  logic                  i_out_ready,
  output logic [ACC_WIDTH-1:0]  o_out_data
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_RUN,
    ST_DRAIN,
    ST_CAPTURE,
    ST_OUT
  } state_t;

  state_t                r_state;
  logic [LEN_WIDTH-1:0]  r_len_q;
  logic [LEN_WIDTH-1:0]  r_cnt;
  logic                  r_busy;
  logic                  r_in_ready;
  logic                  r_out_valid;
  logic [ACC_WIDTH-1:0]  r_out_data;
  logic [DATA_WIDTH-1:0] r_pe_a;
  logic [DATA_WIDTH-1:0] r_pe_b;

  logic w_xfer;
  logic w_last;

  // r_in_ready is high exactly while in RUN, so it doubles as the RUN qualifier
  assign w_xfer = i_in_valid & r_in_ready;
  assign w_last = (r_cnt == (r_len_q - LEN_WIDTH'(1)));

  // The PE clear must act during reset even if the PE itself has no reset
  assign o_pe_clear  = i_reset | (r_state == ST_CLEAR);
  assign o_busy      = r_busy;
  assign o_in_ready  = r_in_ready;
  assign o_out_valid = r_out_valid;
  assign o_out_data  = r_out_data;
  assign o_pe_a      = r_pe_a;
  assign o_pe_b      = r_pe_b;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= ST_IDLE;
      r_len_q     <= '0;
      r_cnt       <= '0;
      r_busy      <= 1'b0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_pe_a      <= '0;
      r_pe_b      <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_len_q <= i_vec_len;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= ST_CLEAR;
          end
        end
        ST_CLEAR: begin
          r_pe_a <= '0;
          r_pe_b <= '0;
          if (r_len_q == '0) begin
            r_state <= ST_CAPTURE;
          end else begin
            r_in_ready <= 1'b1;
            r_state    <= ST_RUN;
          end
        end
        ST_RUN: begin
          // Zero operands on idle cycles so the PE adds nothing
          if (w_xfer) begin
            r_pe_a <= i_in_a;
            r_pe_b <= i_in_b;
            r_cnt  <= r_cnt + LEN_WIDTH'(1);
            if (w_last) begin
              r_in_ready <= 1'b0;
              r_state    <= ST_DRAIN;
            end
          end else begin
            r_pe_a <= '0;
            r_pe_b <= '0;
          end
        end
        ST_DRAIN: begin
          r_pe_a  <= '0;
          r_pe_b  <= '0;
          r_state <= ST_CAPTURE;
        end
        ST_CAPTURE: begin
          r_out_data  <= i_pe_result;
          r_out_valid <= 1'b1;
          r_state     <= ST_OUT;
        end
        ST_OUT: begin
          if (i_out_ready) begin
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_busy      <= 1'b0;
          r_in_ready  <= 1'b0;
          r_out_valid <= 1'b0;
          r_pe_a      <= '0;
          r_pe_b      <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pe_mac_sequencer.sv
// Scoreboard bench for pe_mac_sequencer with a behavioural accumulating PE stub.
module tb_pe_mac_sequencer;

  localparam int unsigned DW = 8;
  localparam int unsigned AW = 32;
  localparam int unsigned LW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          i_reset, i_start, i_in_valid, i_out_ready;
  logic [LW-1:0] i_vec_len;
  logic [DW-1:0] i_in_a, i_in_b;
  logic          o_busy, o_in_ready, o_pe_clear, o_out_valid;
  logic [DW-1:0] o_pe_a, o_pe_b;
  logic [AW-1:0] o_out_data;
  logic [AW-1:0] pe_acc = '0;

  pe_mac_sequencer #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .LEN_WIDTH(LW)) dut (
    .i_clk       (clk),
    .i_reset     (i_reset),
    .i_start     (i_start),
    .i_vec_len   (i_vec_len),
    .o_busy      (o_busy),
    .i_in_valid  (i_in_valid),
    .o_in_ready  (o_in_ready),
    .i_in_a      (i_in_a),
    .i_in_b      (i_in_b),
    .o_pe_a      (o_pe_a),
    .o_pe_b      (o_pe_b),
    .o_pe_clear  (o_pe_clear),
    .i_pe_result (pe_acc),
    .o_out_valid (o_out_valid),
    .i_out_ready (i_out_ready),
    .o_out_data  (o_out_data)
  );

  // PE stub: unsigned product added every clock, cleared by pe_clear
  always @(posedge clk) begin
    if (o_pe_clear) pe_acc <= '0;
    else            pe_acc <= pe_acc + ({24'b0, o_pe_a} * {24'b0, o_pe_b});
  end

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int n_pop = 0, exp_pops = 0, n_xfer = 0, n_ready = 0, n_vcyc = 0, rise_cyc = 0;
  logic prev_hold = 1'b0, prev_ov = 1'b0, post_chk = 1'b0;
  logic [AW-1:0] prev_data = '0;
  logic [AW-1:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: hold stability, post-handshake idle, scoreboard compare
  always @(negedge clk) begin
    if (prev_hold) begin
      check("hold_valid", 64'(o_out_valid), 64'd1);
      check("hold_data", 64'(o_out_data), 64'(prev_data));
    end
    if (post_chk) begin
      check("post_busy", 64'(o_busy), 64'd0);
      check("post_valid", 64'(o_out_valid), 64'd0);
    end
    prev_hold <= o_out_valid && !i_out_ready;
    prev_data <= o_out_data;
    prev_ov   <= o_out_valid;
    post_chk  <= o_out_valid && i_out_ready;
    if (o_out_valid && !prev_ov) rise_cyc <= cyc;
    if (o_out_valid) n_vcyc <= n_vcyc + 1;
    if (o_in_ready) n_ready <= n_ready + 1;
    if (i_in_valid && o_in_ready) n_xfer <= n_xfer + 1;
    if (o_out_valid && i_out_ready) begin
      check("sb_nonempty", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) check("result", 64'(o_out_data), 64'(exp_q.pop_front()));
      n_pop <= n_pop + 1;
    end
  end

  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic start_cmd(input logic [LW-1:0] len, input logic [AW-1:0] exp, input bit expect_result);
    i_start = 1'b1;
    i_vec_len = len;
    if (expect_result) begin
      exp_q.push_back(exp);
      exp_pops++;
    end
    tick();
    i_start = 1'b0;
  endtask

  task automatic send(input logic [DW-1:0] a, input logic [DW-1:0] b);
    int g = 0;
    i_in_valid = 1'b1;
    i_in_a = a;
    i_in_b = b;
    @(negedge clk);
    while (!o_in_ready && g < 50) begin
      @(negedge clk);
      g++;
    end
    check("send_ready", 64'(o_in_ready), 64'd1);
    tick();
    i_in_valid = 1'b0;
    i_in_a = '0;
    i_in_b = '0;
  endtask

  task automatic gap();
    tick();
    check("gap_pe_a", 64'(o_pe_a), 64'd0);
  endtask

  task automatic wait_pop();
    int g = 0;
    while (n_pop < exp_pops && g < 200) begin
      tick();
      g++;
    end
    check("result_seen", 64'(n_pop), 64'(exp_pops));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int t0, v0, x0, r0, g;
    i_reset = 1'b1; i_start = 1'b0; i_vec_len = '0;
    i_in_valid = 1'b0; i_in_a = '0; i_in_b = '0; i_out_ready = 1'b1;

    // Reset and idle
    tick();
    check("rst_pe_clear", 64'(o_pe_clear), 64'd1);
    check("rst_busy", 64'(o_busy), 64'd0);
    check("rst_in_ready", 64'(o_in_ready), 64'd0);
    check("rst_out_valid", 64'(o_out_valid), 64'd0);
    check("rst_out_data", 64'(o_out_data), 64'd0);
    check("rst_pe_a", 64'(o_pe_a), 64'd0);
    tick();
    i_reset = 1'b0;
    repeat (5) tick();
    check("idle_busy", 64'(o_busy), 64'd0);
    check("idle_pe_clear", 64'(o_pe_clear), 64'd0);
    check("idle_out_valid", 64'(o_out_valid), 64'd0);

    // Four pairs back-to-back: 2+12+30+56 = 100, valid 7 edges after start
    v0 = n_vcyc;
    start_cmd(8'd4, 32'd100, 1'b1);
    t0 = cyc;
    check("clr_pe_clear", 64'(o_pe_clear), 64'd1);
    check("clr_busy", 64'(o_busy), 64'd1);
    check("clr_in_ready", 64'(o_in_ready), 64'd0);
    send(8'd1, 8'd2); send(8'd3, 8'd4); send(8'd5, 8'd6); send(8'd7, 8'd8);
    wait_pop();
    check("lat_n4", 64'(rise_cyc - t0), 64'd7);
    tick(); tick();
    check("pulse_n4", 64'(n_vcyc - v0), 64'd1);

    // Gapped input: 100+6+1 = 107, exactly three transfers
    x0 = n_xfer;
    start_cmd(8'd3, 32'd107, 1'b1);
    send(8'd10, 8'd10); gap(); send(8'd2, 8'd3); gap(); send(8'd1, 8'd1);
    wait_pop();
    check("xfer_n3", 64'(n_xfer - x0), 64'd3);

    // Zero-length vector: cleared result, valid 2 edges after start
    r0 = n_ready;
    start_cmd(8'd0, 32'd0, 1'b1);
    t0 = cyc;
    check("z_pe_clear", 64'(o_pe_clear), 64'd1);
    wait_pop();
    check("lat_n0", 64'(rise_cyc - t0), 64'd2);
    check("z_no_ready", 64'(n_ready - r0), 64'd0);

    // Back-pressured result, ignored start in OUT, then a second command
    i_out_ready = 1'b0;
    start_cmd(8'd2, 32'd8, 1'b1);
    send(8'd2, 8'd2); send(8'd2, 8'd2);
    g = 0;
    while (!o_out_valid && g < 50) begin
      tick();
      g++;
    end
    check("b2b_valid", 64'(o_out_valid), 64'd1);
    tick(); tick();
    i_start = 1'b1; i_vec_len = 8'd7;
    tick();
    i_start = 1'b0;
    check("ign_busy", 64'(o_busy), 64'd1);
    check("ign_valid", 64'(o_out_valid), 64'd1);
    check("ign_data", 64'(o_out_data), 64'd8);
    tick(); tick();
    i_out_ready = 1'b1;
    wait_pop();
    start_cmd(8'd1, 32'd1, 1'b1);
    send(8'd1, 8'd1);
    wait_pop();

    // Reset after two of four pairs, then a fresh single pair
    start_cmd(8'd4, 32'd0, 1'b0);
    send(8'd5, 8'd5); send(8'd6, 8'd6);
    i_reset = 1'b1;
    #1;
    check("mid_pe_clear", 64'(o_pe_clear), 64'd1);
    tick();
    i_reset = 1'b0;
    check("mid_busy", 64'(o_busy), 64'd0);
    check("mid_in_ready", 64'(o_in_ready), 64'd0);
    check("mid_pe_a", 64'(o_pe_a), 64'd0);
    v0 = n_vcyc;
    repeat (8) tick();
    check("mid_no_valid", 64'(n_vcyc - v0), 64'd0);
    start_cmd(8'd1, 32'd81, 1'b1);
    send(8'd9, 8'd9);
    wait_pop();

    tick();
    check("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
